// File: rtl/status_reg.sv
`default_nettype none
// ============================================================================
// Module   : status_reg
// Brief    : 6502-style processor status register holding N,V,D,I,Z,C.
// Revision : 1.0 - initial release
// ============================================================================
module status_reg #(
  parameter logic RESET_I = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alu_n,
  input  logic       alu_v,
  input  logic       alu_z,
  input  logic       alu_c,
  input  logic       update_nz,
  input  logic       update_c,
  input  logic       update_v,
  input  logic       bit_test,
  input  logic [2:0] flag_op,
  input  logic       load_p,
  input  logic [7:0] din,
  input  logic       irq_entry,
  input  logic       push_brk,
  output logic [7:0] p,
  output logic [7:0] push_data,
  output logic       d_flag
);

  localparam logic [2:0] c_op_clc = 3'b001;
  localparam logic [2:0] c_op_sec = 3'b010;
  localparam logic [2:0] c_op_cli = 3'b011;
  localparam logic [2:0] c_op_sei = 3'b100;
  localparam logic [2:0] c_op_clv = 3'b101;
  localparam logic [2:0] c_op_cld = 3'b110;
  localparam logic [2:0] c_op_sed = 3'b111;

  logic r_n, r_v, r_d, r_i, r_z, r_c;
  logic w_n, w_v, w_d, w_i, w_z, w_c;

  // Bits 5:4 of the data bus are never stored.
  logic w_unused_din;
  assign w_unused_din = ^din[5:4];

  // Lowest priority sources are applied first so later ones overwrite them.
  always_comb begin
    w_n = r_n;
    w_v = r_v;
    w_d = r_d;
    w_i = r_i;
    w_z = r_z;
    w_c = r_c;

    if (load_p) begin
      w_n = din[7];
      w_v = din[6];
      w_d = din[3];
      w_i = din[2];
      w_z = din[1];
      w_c = din[0];
    end else begin
      if (update_nz) begin
        w_n = alu_n;
        w_z = alu_z;
      end
      if (update_c) begin
        w_c = alu_c;
      end
      if (update_v) begin
        w_v = alu_v;
      end
      if (bit_test) begin
        w_n = din[7];
        w_v = din[6];
        w_z = alu_z;
      end
      case (flag_op)
        c_op_clc: w_c = 1'b0;
        c_op_sec: w_c = 1'b1;
        c_op_cli: w_i = 1'b0;
        c_op_sei: w_i = 1'b1;
        c_op_clv: w_v = 1'b0;
        c_op_cld: w_d = 1'b0;
        c_op_sed: w_d = 1'b1;
        default:  ;
      endcase
    end

    if (irq_entry) begin
      w_i = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_n <= 1'b0;
      r_v <= 1'b0;
      r_d <= 1'b0;
      r_i <= RESET_I;
      r_z <= 1'b0;
      r_c <= 1'b0;
    end else begin
      r_n <= w_n;
      r_v <= w_v;
      r_d <= w_d;
      r_i <= w_i;
      r_z <= w_z;
      r_c <= w_c;
    end
  end

  assign p         = {r_n, r_v, 1'b1, 1'b1,     r_d, r_i, r_z, r_c};
  assign push_data = {r_n, r_v, 1'b1, push_brk, r_d, r_i, r_z, r_c};
  assign d_flag    = r_d;

endmodule
`default_nettype wire

// File: tb/tb_status_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_status_reg
// Brief    : Scoreboard bench for status_reg with directed and random cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_status_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       alu_n, alu_v, alu_z, alu_c;
  logic       update_nz, update_c, update_v, bit_test;
  logic [2:0] flag_op;
  logic       load_p;
  logic [7:0] din;
  logic       irq_entry, push_brk;
  logic [7:0] p, push_data;
  logic       d_flag;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic       mn, mv, md, mi, mz, mc;

  always #5 clk = ~clk;

  status_reg dut (
    .clk(clk), .rst(rst),
    .alu_n(alu_n), .alu_v(alu_v), .alu_z(alu_z), .alu_c(alu_c),
    .update_nz(update_nz), .update_c(update_c), .update_v(update_v),
    .bit_test(bit_test), .flag_op(flag_op), .load_p(load_p), .din(din),
    .irq_entry(irq_entry), .push_brk(push_brk),
    .p(p), .push_data(push_data), .d_flag(d_flag)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, expv);
    end
  endtask

  task automatic clear_inputs();
    {alu_n, alu_v, alu_z, alu_c} = 4'b0;
    {update_nz, update_c, update_v, bit_test} = 4'b0;
    flag_op = 3'b000; load_p = 1'b0; din = 8'h00;
    irq_entry = 1'b0; push_brk = 1'b0;
  endtask

  task automatic model_reset();
    {mn, mv, md, mi, mz, mc} = 6'b000100;
  endtask

  // Predict the flags from the current inputs, clock once, compare the outputs.
  task automatic step(input string tag);
    logic nn, nv, nd, ni, nz, nc;
    logic [7:0] e;
    if (load_p) begin
      {nn, nv} = din[7:6];
      {nd, ni, nz, nc} = din[3:0];
    end else begin
      nn = bit_test ? din[7] : (update_nz ? alu_n : mn);
      nv = bit_test ? din[6] : (update_v ? alu_v : mv);
      nz = (bit_test || update_nz) ? alu_z : mz;
      nc = update_c ? alu_c : mc;
      nd = md;
      ni = mi;
      case (flag_op)
        3'd1: nc = 1'b0;
        3'd2: nc = 1'b1;
        3'd3: ni = 1'b0;
        3'd4: ni = 1'b1;
        3'd5: nv = 1'b0;
        3'd6: nd = 1'b0;
        3'd7: nd = 1'b1;
        default: ;
      endcase
    end
    if (irq_entry) ni = 1'b1;
    exp_q.push_back({nn, nv, 2'b11, nd, ni, nz, nc});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, ".p"}, p, e);
    check({tag, ".push_data"}, push_data, {e[7:6], 1'b1, push_brk, e[3:0]});
    check({tag, ".d_flag"}, {7'b0, d_flag}, {7'b0, e[3]});
    {mn, mv} = e[7:6];
    {md, mi, mz, mc} = e[3:0];
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_p", p, 8'h34);
    check("reset_d", {7'b0, d_flag}, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // ALU capture of all four flags
    @(negedge clk);
    clear_inputs();
    {alu_n, alu_z, alu_c, alu_v} = 4'b1011;
    {update_nz, update_c, update_v} = 3'b111;
    step("alu");
    check("alu_cap", p, 8'hF5);

    // whole-register load, then the two stack images
    @(negedge clk);
    clear_inputs();
    load_p = 1'b1; din = 8'hCB;
    update_c = 1'b1; flag_op = 3'b001;
    step("load");
    check("load_p", p, 8'hFB);
    push_brk = 1'b0; #1;
    check("push_brk0", push_data, 8'hEB);
    push_brk = 1'b1; #1;
    check("push_brk1", push_data, 8'hFB);

    // CLC beats a simultaneous carry capture; SED reaches d_flag
    @(negedge clk);
    clear_inputs();
    flag_op = 3'b001; update_c = 1'b1; alu_c = 1'b1;
    step("clc");
    check("clc_wins", {7'b0, p[0]}, 8'h00);
    @(negedge clk);
    clear_inputs();
    flag_op = 3'b111;
    step("sed");
    check("sed_d", {7'b0, d_flag}, 8'h01);

    // BIT overrides update_nz for N and Z
    @(negedge clk);
    clear_inputs();
    din = 8'h40; alu_z = 1'b1; bit_test = 1'b1; update_nz = 1'b1; alu_n = 1'b1;
    step("bit");
    check("bit_nvz", {5'b0, p[7], p[6], p[1]}, 8'h03);

    // IRQ entry sets I despite CLI and a zero load
    @(negedge clk);
    clear_inputs();
    flag_op = 3'b011;
    step("cli");
    check("cli_i", {7'b0, p[2]}, 8'h00);
    @(negedge clk);
    clear_inputs();
    irq_entry = 1'b1; flag_op = 3'b011; load_p = 1'b1; din = 8'h00;
    step("irq");
    check("irq_p", p, 8'h34);

    // random traffic
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      {alu_n, alu_v, alu_z, alu_c} = 4'($urandom);
      update_nz = 1'($urandom);
      update_c  = 1'($urandom);
      update_v  = 1'($urandom);
      bit_test  = ($urandom_range(0, 3) == 0);
      flag_op   = ($urandom_range(0, 1) == 0) ? 3'($urandom) : 3'b000;
      load_p    = ($urandom_range(0, 7) == 0);
      irq_entry = ($urandom_range(0, 7) == 0);
      push_brk  = 1'($urandom);
      din       = 8'($urandom);
      step("rnd");
    end

    // mid-operation asynchronous reset with updates pending
    @(negedge clk);
    clear_inputs();
    load_p = 1'b1; din = 8'hFF;
    step("preload");
    @(negedge clk);
    {alu_n, alu_c, alu_v} = 3'b111;
    {update_nz, update_c, update_v} = 3'b111;
    flag_op = 3'b111;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_p", p, 8'h34);
    check("async_rst_d", {7'b0, d_flag}, 8'h00);
    @(posedge clk);
    #1;
    check("rst_hold_p", p, 8'h34);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    clear_inputs();
    step("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/status_reg.md
STATUS_REG -- requirements
Module: status_reg

Interface
REQ-001 SHALL have parameter RESET_I, default 1, giving the I flag value after reset.
REQ-002 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port alu_n, input, 1, N result from the ALU.
REQ-005 SHALL have port alu_v, input, 1, V result from the ALU.
REQ-006 SHALL have port alu_z, input, 1, Z result from the ALU.
REQ-007 SHALL have port alu_c, input, 1, CO result from the ALU.
REQ-008 SHALL have port update_nz, input, 1, capture alu_n/alu_z.
REQ-009 SHALL have port update_c, input, 1, capture alu_c.
REQ-010 SHALL have port update_v, input, 1, capture alu_v.
REQ-011 SHALL have port bit_test, input, 1, BIT instruction; N<=din[7], V<=din[6], Z<=alu_z.
REQ-012 SHALL have port flag_op, input, 3, explicit flag op: 000 none, 001 CLC, 010 SEC, 011 CLI, 100 SEI, 101 CLV, 110 CLD, 111 SED.
REQ-013 SHALL have port load_p, input, 1, load the whole register from din (PLP/RTI).
REQ-014 SHALL have port din, input, 8, data bus byte for load_p and bit_test.
REQ-015 SHALL have port irq_entry, input, 1, interrupt or BRK entry; sets I.
REQ-016 SHALL have port push_brk, input, 1, selects the B value in push_data.
REQ-017 SHALL have port p, output, 8, live status {N,V,1,1,D,I,Z,C}.
REQ-018 SHALL have port push_data, output, 8, stack image {N,V,1,push_brk,D,I,Z,C}.
REQ-019 SHALL have port d_flag, output, 1, D flag driven to the ALU D input.

Function
REQ-020 SHALL hold six registered flags N,V,D,I,Z,C; bit5 and bit4 are not stored.
REQ-021 SHALL make every update visible on p, push_data and d_flag one clk edge after the qualifying inputs are sampled; outputs are combinational from the registers only.
REQ-022 SHALL, when load_p=1, load N,V,D,I,Z,C from din[7],din[6],din[3],din[2],din[1],din[0], ignore din[5:4], and ignore update_*, bit_test and flag_op that cycle.
REQ-023 SHALL, when update_nz=1 and load_p=0, capture N<=alu_n and Z<=alu_z.
REQ-024 SHALL, when update_c=1 and load_p=0, capture C<=alu_c.
REQ-025 SHALL, when update_v=1 and load_p=0, capture V<=alu_v.
REQ-026 SHALL, when bit_test=1 and load_p=0, take N and V from din and Z from alu_z; bit_test overrides update_nz and update_v for N, V and Z.
REQ-027 SHALL apply flag_op to its target flag only; when flag_op and an update_* or bit_test target the same flag in one cycle, flag_op wins.
REQ-028 SHALL, when irq_entry=1, set I<=1 regardless of load_p, flag_op or any other input; all other flags follow the rules above.
REQ-029 SHALL hold every flag not targeted in a cycle.
REQ-030 SHALL use priority rst > irq_entry (I only) > load_p > flag_op > bit_test > update_*.

Reset
REQ-031 SHALL, on rst assertion, immediately and asynchronously set N=V=D=Z=C=0 and I=RESET_I, giving p=8'h34 when RESET_I=1.
REQ-032 SHALL ignore all inputs while rst=1 and resume on the first clk edge after deassertion.
REQ-033 SHALL have reset mid-operation override any update pending in that cycle.

Verification
REQ-034 SHALL cover reset: assert rst between edges -> p=8'h34 and d_flag=0 with no clk edge.
REQ-035 SHALL cover ALU capture: alu_n=1,alu_z=0,alu_c=1,alu_v=1, update_nz=update_c=update_v=1 -> next cycle p=8'hF5.
REQ-036 SHALL cover load and push: load_p=1, din=8'hCB -> p=8'hFB; push_brk=0 -> push_data=8'hEB; push_brk=1 -> push_data=8'hFB.
REQ-037 SHALL cover the conflict: flag_op=001 (CLC) with update_c=1, alu_c=1 -> C=0; SED -> d_flag=1 next cycle.
REQ-038 SHALL cover BIT: din=8'h40, alu_z=1, bit_test=1, update_nz=1, alu_n=1 -> N=0, V=1, Z=1.
REQ-039 SHALL cover IRQ entry: I=0, irq_entry=1 with flag_op=011 (CLI) and load_p=1, din=8'h00 -> I=1, all other flags 0.
